// File: rtl/c2arb_pkg.sv
// Shared types and helpers for the C2 mux arbiter.
// Fixed-priority option: C2ARB_FIXED_PRIO_EN.
package c2arb_pkg;

  localparam int N_SRC = 4;

  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  // {a1,b1,a0,b0}: S[1]=A1|B1, S[0]=A0&B0
  function automatic logic [3:0] sel_map(
    input logic [1:0] s
  );
    return {s[1], 1'b0, s[0], s[0]};
  endfunction

endpackage

// File: rtl/c2_mux_arbiter_rr_pick4.sv
// Four-way winner picker: round-robin from ptr, or
// lowest-index-first when C2ARB_FIXED_PRIO_EN is defined.
module rr_pick4
  import c2arb_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [1:0]       ptr,
  output logic [N_SRC-1:0] win,
  output logic [1:0]       idx
);

`ifdef C2ARB_FIXED_PRIO_EN

  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = '0;
    for (int i = N_SRC-1; i >= 0; i--)
      if (req[i]) idx = 2'(i);
    win = '0;
    if (|req) win[idx] = 1'b1;
  end

`else

  logic [2*N_SRC-1:0] dbl;
  logic [N_SRC-1:0]   rot;
  logic [1:0]         off;

  // rot[j] is req[(ptr+j) mod 4]
  always_comb begin
    dbl = {req, req};
    rot = dbl[ptr +: N_SRC];
    off = '0;
    for (int i = N_SRC-1; i >= 0; i--)
      if (rot[i]) off = 2'(i);
    idx = ptr + off;
    win = '0;
    if (|req) win[idx] = 1'b1;
  end

`endif

endmodule

// File: rtl/c2_mux_arbiter.sv
// Shares one C2 4:1 mux among four requesters.
// Define C2ARB_FIXED_PRIO_EN for fixed priority.
module c2_mux_arbiter #(
  parameter int SIZE   = 5,
  parameter int SETTLE = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [c2arb_pkg::N_SRC-1:0] req,
  input  logic [SIZE-1:0]            mux_out,
  output logic                       sel_a1,
  output logic                       sel_b1,
  output logic                       sel_a0,
  output logic                       sel_b0,
  output logic [c2arb_pkg::N_SRC-1:0] grant,
  output logic [SIZE-1:0]            data_out,
  output logic                       data_valid
);

  import c2arb_pkg::*;

  if (SETTLE < SETTLE_MIN || SETTLE > SETTLE_MAX) begin : g_bad
    $error("c2_mux_arbiter: SETTLE must be 1..15");
  end

  localparam logic [3:0] CNT_LD = 4'(SETTLE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       cnt;
  logic [1:0]       ptr;
  logic [3:0]       sel_q;
  logic [N_SRC-1:0] win;
  logic [1:0]       win_idx;
  logic             ld;
  logic             cap;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr),
    .win (win),
    .idx (win_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (|req) state_nxt = c2arb_pkg::SETTLE;
      c2arb_pkg::SETTLE:
        if (cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ld  = 1'b0;
    cap = 1'b0;
    unique case (state)
      IDLE:              ld  = |req;
      c2arb_pkg::SETTLE: cap = (cnt == '0);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      ptr        <= '0;
      sel_q      <= '0;
      grant      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= cap;
      if (ld) begin
        grant <= win;
        sel_q <= sel_map(win_idx);
        cnt   <= CNT_LD;
      end else if (state == c2arb_pkg::SETTLE
                   && cnt != '0) begin
        cnt <= cnt - 4'd1;
      end
      if (cap) begin
        data_out <= mux_out;
        grant    <= '0;
`ifdef C2ARB_FIXED_PRIO_EN
        ptr      <= '0;
`else
        // granted index is recoverable from A1/A0
        ptr      <= {sel_q[3], sel_q[1]} + 2'd1;
`endif
      end
    end
  end

  assign {sel_a1, sel_b1, sel_a0, sel_b0} = sel_q;

endmodule

// File: tb/tb_c2_mux_arbiter.sv
// Bench for c2_mux_arbiter with a delayed C2 model.
// Build with C2ARB_FIXED_PRIO_EN to test fixed priority.
`timescale 1ps/1ps
module tb_c2_mux_arbiter;

  localparam int SIZE = 5;
  localparam int ST   = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      req = '0;
  logic [SIZE-1:0] mux_out;
  logic            sel_a1, sel_b1;
  logic            sel_a0, sel_b0;
  logic [3:0]      grant;
  logic [SIZE-1:0] data_out;
  logic            data_valid;

  logic [SIZE-1:0] dv [4];
  logic [1:0]      csel;

  assign csel = {sel_a1 | sel_b1,
                 sel_a0 & sel_b0};
  assign #2500 mux_out = dv[csel];

  always #500 clk = ~clk;

  c2_mux_arbiter #(
    .SIZE   (SIZE),
    .SETTLE (ST)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mux_out    (mux_out),
    .sel_a1     (sel_a1),
    .sel_b1     (sel_b1),
    .sel_a0     (sel_a0),
    .sel_b0     (sel_b0),
    .grant      (grant),
    .data_out   (data_out),
    .data_valid (data_valid)
  );

  typedef struct {
    int              idx;
    logic [SIZE-1:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] req;
    int         rr;
    int         fp;
  } vec_t;

  exp_t sbq[$];
  vec_t tv[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic txn(input logic [3:0] r,
                     input int ei,
                     input bit drop);
    exp_t       e;
    int         n;
    logic [1:0] s;
    s      = 2'(ei);
    req    = r;
    e.idx  = ei;
    e.data = dv[ei];
    sbq.push_back(e);
    step();
    chk("grant", 32'(grant), 32'd1 << ei);
    chk("sel", {sel_a1, sel_b1, sel_a0, sel_b0},
        {28'd0, s[1], 1'b0, s[0], s[0]});
    if (drop) req = '0;
    n = 0;
    while (!data_valid && n < 16) begin
      step();
      n++;
    end
    e = sbq.pop_front();
    chk("dv_seen", 32'(data_valid), 32'd1);
    if (data_valid) begin
      chk("data", 32'(data_out), 32'(e.data));
      chk("latency", n, ST);
      chk("grant_clr", 32'(grant), 32'd0);
    end
    req = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    int ei;
    dv[0] = 5'h0A;
    dv[1] = 5'h13;
    dv[2] = 5'h15;
    dv[3] = 5'h1E;
    tv[0] = '{4'hF,    0, 0};
    tv[1] = '{4'hF,    1, 0};
    tv[2] = '{4'hF,    2, 0};
    tv[3] = '{4'hF,    3, 0};
    tv[4] = '{4'hF,    0, 0};
    tv[5] = '{4'b1000, 3, 3};
    tv[6] = '{4'b0011, 0, 0};
    tv[7] = '{4'b0011, 1, 0};
    tv[8] = '{4'b0110, 2, 1};
    tv[9] = '{4'b0101, 0, 0};

    rst_n = 1'b0;
    req   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_out",
          {grant, sel_a1, sel_b1, sel_a0, sel_b0,
           data_out, data_valid}, 32'd0);
    end
    rst_n = 1'b1;
    req   = '0;
    step();

    txn(4'b0100, 2, 1'b0);

    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
`ifdef C2ARB_FIXED_PRIO_EN
      ei = tv[i].fp;
`else
      ei = tv[i].rr;
`endif
      txn(tv[i].req, ei, 1'b0);
    end

    txn(4'b0010, 1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("no_regrant", {grant, data_valid}, 32'd0);
      chk("hold_data", 32'(data_out), 32'(dv[1]));
      chk("hold_sel",
          {sel_a1, sel_b1, sel_a0, sel_b0}, 32'b0011);
    end

    req = 4'b1000;
    step();
    chk("mid_grant", 32'(grant), 32'b1000);
    step();
    rst_n = 1'b0;
    step();
    chk("mid_reset",
        {grant, sel_a1, sel_b1, sel_a0, sel_b0,
         data_out, data_valid}, 32'd0);
    rst_n = 1'b1;
    req   = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_dv", {grant, data_valid}, 32'd0);
    end

    txn(4'b1000, 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
